// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: control from hazard/EX, imem request/response port, IF/ID outputs.
// master is the fetch stage; slave is the surrounding pipeline and instruction memory.
interface fetch_stage_if;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;

   logic        ifid_valid;
   logic [63:0] ifid_pc;
   logic [31:0] ifid_instr;

   modport master (
      input  stall, redirect_valid, redirect_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      output imem_req_valid, imem_req_addr,
      output ifid_valid, ifid_pc, ifid_instr
   );

   modport slave (
      output stall, redirect_valid, redirect_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      input  imem_req_valid, imem_req_addr,
      input  ifid_valid, ifid_pc, ifid_instr
   );
endinterface

// File: rtl/fetch_stage.sv
// RV64I instruction fetch + IF/ID register: 2-credit imem requests, 2-entry fetch queue.
// Latency accept->IF/ID 2 cycles on 1-cycle memory; stall holds IF/ID while credits throttle requests.
module fetch_stage #(
   parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic           clk,
   input  logic           rst_n,
   fetch_stage_if.master  bus
);

   logic [63:0] pc;
   logic [1:0]  out_cnt;
   logic [1:0]  drop_cnt;

   // Addresses of outstanding requests; occupancy always equals out_cnt.
   logic [63:0] pcf [2];
   logic        pf_wr;
   logic        pf_rd;

   logic [63:0] q_pc    [2];
   logic [31:0] q_instr [2];
   logic        q_wr;
   logic        q_rd;
   logic [1:0]  q_cnt;

   logic        ifid_valid_q;
   logic [63:0] ifid_pc_q;
   logic [31:0] ifid_instr_q;

   logic [2:0]  occ;
   logic        req_vld;
   logic        req_fire;
   logic        resp_vld;
   logic [63:0] resp_pc;
   logic        resp_keep;
   logic        ifid_load;
   logic        bypass;
   logic        q_push;
   logic        q_pop;

   always_comb begin
      occ       = {1'b0, out_cnt} + {1'b0, q_cnt};
      req_vld   = rst_n && !bus.redirect_valid && (occ < 3'd2);
      req_fire  = req_vld && bus.imem_req_ready;
      resp_vld  = bus.imem_resp_valid;
      resp_pc   = pcf[pf_rd];
      resp_keep = resp_vld && (drop_cnt == 2'd0) && !bus.redirect_valid;
      ifid_load = !bus.stall && !bus.redirect_valid;
      q_pop     = ifid_load && (q_cnt != 2'd0);
      bypass    = resp_keep && (q_cnt == 2'd0) && ifid_load;
      q_push    = resp_keep && !bypass;
   end

   assign bus.imem_req_valid = req_vld;
   assign bus.imem_req_addr  = pc;
   assign bus.ifid_valid     = ifid_valid_q;
   assign bus.ifid_pc        = ifid_pc_q;
   assign bus.ifid_instr     = ifid_instr_q;

   // Storage arrays carry no reset; their pointers and counts do.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         pcf[pf_wr] <= pc;
      end
      if (q_push) begin
         q_pc[q_wr]    <= resp_pc;
         q_instr[q_wr] <= bus.imem_resp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc           <= RESET_PC;
         out_cnt      <= 2'd0;
         drop_cnt     <= 2'd0;
         pf_wr        <= 1'b0;
         pf_rd        <= 1'b0;
         q_wr         <= 1'b0;
         q_rd         <= 1'b0;
         q_cnt        <= 2'd0;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= 64'd0;
         ifid_instr_q <= NOP_INSTR;
      end else begin
         if (req_fire) begin
            pf_wr <= ~pf_wr;
         end
         if (resp_vld) begin
            pf_rd <= ~pf_rd;
         end
         out_cnt <= out_cnt + {1'b0, req_fire} - {1'b0, resp_vld};

         if (bus.redirect_valid) begin
            // Stale requests stay in the PC FIFO and are popped by their responses.
            pc           <= bus.redirect_pc & ~64'h3;
            drop_cnt     <= out_cnt - {1'b0, resp_vld};
            q_cnt        <= 2'd0;
            q_wr         <= 1'b0;
            q_rd         <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
         end else begin
            if (req_fire) begin
               pc <= pc + 64'd4;
            end
            if (resp_vld && (drop_cnt != 2'd0)) begin
               drop_cnt <= drop_cnt - 2'd1;
            end
            if (q_push) begin
               q_wr <= ~q_wr;
            end
            if (q_pop) begin
               q_rd <= ~q_rd;
            end
            q_cnt <= q_cnt + {1'b0, q_push} - {1'b0, q_pop};

            if (ifid_load) begin
               if (q_cnt != 2'd0) begin
                  ifid_valid_q <= 1'b1;
                  ifid_pc_q    <= q_pc[q_rd];
                  ifid_instr_q <= q_instr[q_rd];
               end else if (bypass) begin
                  ifid_valid_q <= 1'b1;
                  ifid_pc_q    <= resp_pc;
                  ifid_instr_q <= bus.imem_resp_data;
               end else begin
                  ifid_valid_q <= 1'b0;
                  ifid_instr_q <= NOP_INSTR;
               end
            end
         end
      end
   end

   a_resp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
      bus.imem_resp_valid |-> (out_cnt != 2'd0));

   a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
      occ <= 3'd2);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a transaction-level model (request list with stale marks,
// instruction queue) predicts every output each cycle; a few literal checks pin the model.
module tb_fetch_stage;
   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fetch_stage_if bus ();

   fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int first_fire = -1;

   // stimulus knobs applied at the next cycle
   logic        k_rst_n = 1'b0;
   logic        k_stall = 1'b0;
   logic        k_redir = 1'b0;
   logic [63:0] k_rpc   = 64'd0;
   logic        k_ready = 1'b1;
   int          k_lat_lo = 1;
   int          k_lat_hi = 1;

   // instruction memory: in-order, latency per request
   typedef struct { logic [63:0] addr; int due; } mreq_t;
   mreq_t memq[$];
   int last_due = 0;

   // reference model
   typedef struct { logic [63:0] addr; bit stale; } oreq_t;
   typedef struct { logic [63:0] pc; logic [31:0] instr; } fq_t;
   oreq_t outq[$];
   fq_t   fq[$];
   logic [63:0] m_pc    = RESET_PC;
   logic        m_v     = 1'b0;
   logic [63:0] m_ifpc  = 64'd0;
   logic [31:0] m_instr = NOP;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s cyc=%0d: bound expired or unexpected event", name, cyc);
   endtask

   task automatic compare_and_step();
      logic   exp_v;
      logic   fire;
      logic   dut_fire;
      oreq_t  e;
      fq_t    f;
      int     due;
      exp_v = rst_n && !bus.redirect_valid && ((outq.size() + fq.size()) < 2);
      chk("req_valid", bus.imem_req_valid, exp_v);
      if (exp_v) chk("req_addr", bus.imem_req_addr, m_pc);
      chk("ifid_valid", bus.ifid_valid, m_v);
      chk("ifid_instr", bus.ifid_instr, m_instr);
      if (m_v) chk("ifid_pc", bus.ifid_pc, m_ifpc);

      dut_fire = rst_n && bus.imem_req_valid && bus.imem_req_ready;
      if (!rst_n) begin
         memq.delete();
         last_due = 0;
      end else if (dut_fire) begin
         due = cyc + int'($urandom_range(k_lat_hi, k_lat_lo));
         if (due <= last_due) due = last_due + 1;
         memq.push_back('{addr: bus.imem_req_addr, due: due});
         last_due = due;
         if (first_fire < 0) first_fire = cyc;
      end

      fire = exp_v && bus.imem_req_ready;
      if (!rst_n) begin
         outq.delete();
         fq.delete();
         m_pc = RESET_PC;
         m_v = 1'b0;
         m_ifpc = 64'd0;
         m_instr = NOP;
      end else begin
         e = '{addr: 64'd0, stale: 1'b1};
         if (bus.imem_resp_valid) begin
            if (outq.size() == 0) fail("resp_orphan");
            else e = outq.pop_front();
         end
         if (bus.redirect_valid) begin
            foreach (outq[i]) outq[i].stale = 1'b1;
            fq.delete();
            m_pc = bus.redirect_pc & ~64'h3;
            m_v = 1'b0;
            m_instr = NOP;
         end else begin
            if (fire) begin
               outq.push_back('{addr: m_pc, stale: 1'b0});
               m_pc = m_pc + 64'd4;
            end
            if (bus.imem_resp_valid && !e.stale)
               fq.push_back('{pc: e.addr, instr: bus.imem_resp_data});
            if (!bus.stall) begin
               if (fq.size() > 0) begin
                  f = fq.pop_front();
                  m_v = 1'b1;
                  m_ifpc = f.pc;
                  m_instr = f.instr;
               end else begin
                  m_v = 1'b0;
                  m_instr = NOP;
               end
            end
         end
      end
   endtask

   task automatic tick();
      logic [63:0] a;
      @(posedge clk);
      #1;
      cyc++;
      rst_n = k_rst_n;
      bus.stall = k_stall;
      bus.redirect_valid = k_redir;
      bus.redirect_pc = k_rpc;
      bus.imem_req_ready = k_ready;
      if (k_rst_n && memq.size() > 0 && memq[0].due <= cyc) begin
         a = memq[0].addr;
         bus.imem_resp_valid = 1'b1;
         bus.imem_resp_data = a[31:0];
         void'(memq.pop_front());
      end else begin
         bus.imem_resp_valid = 1'b0;
         bus.imem_resp_data = $urandom;
      end
      @(negedge clk);
      compare_and_step();
   endtask

   initial begin
      logic [63:0] hold_pc;
      logic [31:0] hold_i;
      bit found;
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc = 64'd0;
      bus.imem_req_ready = 1'b1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data = 32'd0;

      // reset state
      repeat (3) tick();
      chk("rst_req_valid", bus.imem_req_valid, 1'b0);
      chk("rst_ifid_valid", bus.ifid_valid, 1'b0);
      chk("rst_ifid_pc", bus.ifid_pc, 64'd0);
      chk("rst_ifid_instr", bus.ifid_instr, NOP);

      // streaming, 1-cycle memory
      k_rst_n = 1'b1;
      tick();
      chk("first_addr", bus.imem_req_addr, 64'h8000_0000);
      tick();
      chk("second_addr", bus.imem_req_addr, 64'h8000_0004);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (bus.ifid_valid) found = 1;
      end
      if (!found) fail("first_valid");
      else begin
         chk("first_latency", 64'(cyc - first_fire), 64'd2);
         chk("first_ifid_pc", bus.ifid_pc, 64'h8000_0000);
         chk("first_ifid_instr", bus.ifid_instr, 32'h8000_0000);
      end
      repeat (10) tick();

      // stall for 3 cycles while streaming
      k_stall = 1'b1;
      tick();
      hold_pc = bus.ifid_pc;
      hold_i = bus.ifid_instr;
      tick();
      tick();
      chk("stall_req_blocked", bus.imem_req_valid, 1'b0);
      chk("stall_hold_pc", bus.ifid_pc, hold_pc);
      chk("stall_hold_instr", bus.ifid_instr, hold_i);
      k_stall = 1'b0;
      tick();
      tick();
      chk("release_pc1", bus.ifid_pc, hold_pc + 64'd4);
      tick();
      chk("release_pc2", bus.ifid_pc, hold_pc + 64'd8);

      // redirect with two requests outstanding
      k_lat_lo = 2; k_lat_hi = 2;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (outq.size() == 2) found = 1;
      end
      if (!found) fail("two_outstanding");
      k_redir = 1'b1;
      k_rpc = 64'h8000_1003;
      tick();
      k_redir = 1'b0;
      k_lat_lo = 1; k_lat_hi = 1;
      tick();
      chk("redir_bubble", bus.ifid_valid, 1'b0);
      chk("redir_req_valid", bus.imem_req_valid, 1'b1);
      chk("redir_addr", bus.imem_req_addr, 64'h8000_1000);
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         tick();
         if (bus.ifid_valid) found = 1;
      end
      if (!found) fail("redir_first_valid");
      else chk("redir_first_pc", bus.ifid_pc, 64'h8000_1000);

      // redirect coinciding with stall and a response, second request outstanding
      k_lat_lo = 2; k_lat_hi = 2;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (outq.size() == 2 && memq.size() > 0 && memq[0].due <= cyc + 1) found = 1;
      end
      if (!found) fail("redir_stall_setup");
      k_redir = 1'b1;
      k_stall = 1'b1;
      k_rpc = 64'h8000_2000;
      tick();
      k_redir = 1'b0;
      k_stall = 1'b0;
      tick();
      chk("redir_stall_bubble", bus.ifid_valid, 1'b0);
      repeat (8) tick();

      // address wrap
      k_lat_lo = 1; k_lat_hi = 1;
      k_redir = 1'b1;
      k_rpc = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      k_redir = 1'b0;
      tick();
      chk("wrap_addr", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      repeat (10) tick();

      // randomized traffic
      k_lat_lo = 1; k_lat_hi = 3;
      for (int i = 0; i < 3000; i++) begin
         k_rst_n = ($urandom_range(0, 399) != 0);
         k_ready = ($urandom_range(0, 3) != 0);
         k_stall = ($urandom_range(0, 4) == 0);
         k_redir = ($urandom_range(0, 29) == 0);
         k_rpc = {$urandom, $urandom};
         tick();
      end
      k_rst_n = 1'b1; k_ready = 1'b1; k_stall = 1'b0; k_redir = 1'b0;
      k_lat_lo = 1; k_lat_hi = 1;
      repeat (8) tick();

      // one-cycle reset mid-stream
      k_rst_n = 1'b0;
      tick();
      chk("mid_rst_req_valid", bus.imem_req_valid, 1'b0);
      k_rst_n = 1'b1;
      tick();
      chk("mid_rst_ifid_valid", bus.ifid_valid, 1'b0);
      chk("mid_rst_ifid_pc", bus.ifid_pc, 64'd0);
      chk("mid_rst_ifid_instr", bus.ifid_instr, NOP);
      chk("mid_rst_addr", bus.imem_req_addr, 64'h8000_0000);
      repeat (10) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
